// File: rtl/counter_display_pkg.sv
// Shared types and constants for the counter display multiplexer.
//   state_t  : run/pause state of the counter FSM
//   bcd_t    : one decimal digit, 4 bits, legal values 0..9
//   seg_of() : 7-segment code of a digit, seg[0]=A .. seg[6]=G, active-high
package counter_display_pkg;

   typedef enum logic {
      PAUSE = 1'b0,
      RUN   = 1'b1
   } state_t;

   typedef logic [3:0] bcd_t;

   // Entry [n] is the segment code of digit n.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b1101111,   // 9
      7'b1111111,   // 8
      7'b0000111,   // 7
      7'b1111101,   // 6
      7'b1101101,   // 5
      7'b1100110,   // 4
      7'b1001111,   // 3
      7'b1011011,   // 2
      7'b0000110,   // 1
      7'b0111111    // 0
   };

   function automatic logic [6:0] seg_of(bcd_t d);
      if (d > 4'd9) return 7'b0000000;
      return SEG_TABLE[d];
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, debounce, press detect.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   btn    : raw asynchronous button, high = pressed
//   press  : one-cycle pulse per accepted press (0->1); release gives nothing
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYC - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          armed;
   logic [CW-1:0] cnt;
   logic          lvl_eff;
   logic          accept;

   // Until a debounced low has been seen after reset the button is treated
   // as pressed, so a button held through reset release cannot fire a press.
   assign lvl_eff = level | ~armed;
   assign accept  = (sync2 != lvl_eff) && (cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         armed <= 1'b0;
         press <= 1'b0;
         cnt   <= RELOAD;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= accept & sync2;
         if (sync2 == lvl_eff) begin
            cnt <= RELOAD;
         end else if (accept) begin
            level <= sync2;
            armed <= 1'b1;
            cnt   <= RELOAD;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: rtl/counter_display_mux.sv
// Run/pause BCD up/down counter with multiplexed 7-segment display.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   btn   : raw push-button, each press toggles run/pause
//   down  : 1 = count down, 0 = count up (sampled on tick)
//   clr   : synchronous clear of all digits, active-high
//   seg   : segment code of the scanned digit, seg[0]=A .. seg[6]=G
//   dp    : decimal point, lit on digit 0 while paused
//   an    : one-hot digit enable, an[0] = least significant digit
//
// state | meaning
// PAUSE | ticks ignored, value held, dp lit on digit 0
// RUN   | value steps by one on every tick
module counter_display_mux
   import counter_display_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int TICK_DIV     = 50_000_000,
   parameter int SCAN_DIV     = 50_000,
   parameter int DEBOUNCE_CYC = 500_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn,
   input  logic              down,
   input  logic              clr,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [DIGITS-1:0] an
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   // Prescalers count down and reload from zero; the terminal count is 1 so
   // the first pulse lands exactly DIV cycles after reset release.
   localparam logic [SW-1:0] SCAN_TC = (SCAN_DIV > 1) ? SW'(1) : SW'(0);

   state_t        state, state_n;
   logic          press;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [SW-1:0] scan_cnt;
   logic          step;
   logic [IW-1:0] idx, idx_n;
   bcd_t          digits   [DIGITS];
   bcd_t          digits_n [DIGITS];
   logic          carry;

   btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_btn_debounce (
      .clk  (clk),
      .reset(reset),
      .btn  (btn),
      .press(press)
   );

   assign tick = (tick_cnt == TW'(1));
   assign step = (scan_cnt == SCAN_TC);

   always_comb begin
      state_n = state;
      if (press) state_n = (state == RUN) ? PAUSE : RUN;
   end

   always_comb begin
      idx_n = idx;
      if (step) idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
   end

   // Ripple carry/borrow through the digits; a carry out of the top digit is
   // dropped, which gives the 99..9 <-> 00..0 wrap.
   always_comb begin
      digits_n = digits;
      carry    = 1'b1;
      if (clr) begin
         for (int i = 0; i < DIGITS; i++) digits_n[i] = '0;
      end else if (tick && (state == RUN)) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
               if (down) begin
                  if (digits[i] == 4'd0) begin
                     digits_n[i] = 4'd9;
                  end else begin
                     digits_n[i] = digits[i] - 4'd1;
                     carry       = 1'b0;
                  end
               end else begin
                  if (digits[i] == 4'd9) begin
                     digits_n[i] = 4'd0;
                  end else begin
                     digits_n[i] = digits[i] + 4'd1;
                     carry       = 1'b0;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= PAUSE;
         tick_cnt <= '0;
         scan_cnt <= '0;
         idx      <= '0;
         digits   <= '{default: '0};
         seg      <= seg_of(4'd0);
      end else begin
         state    <= state_n;
         tick_cnt <= (tick_cnt == '0) ? TW'(TICK_DIV - 1) : tick_cnt - TW'(1);
         scan_cnt <= (scan_cnt == '0) ? SW'(SCAN_DIV - 1) : scan_cnt - SW'(1);
         idx      <= idx_n;
         digits   <= digits_n;
         // Built from next-cycle values so seg always matches the current an.
         seg      <= seg_of(digits_n[idx_n]);
      end
   end

   always_comb begin
      an      = '0;
      an[idx] = 1'b1;
   end

   assign dp = (idx == '0) && (state == PAUSE);

endmodule
